// File: rtl/rr_bus_arbiter_pkg.sv
// Shared definitions for the four-requester round-robin bus arbiter:
// state encoding, requester count, select width and a one-hot helper.
package rr_bus_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;
  localparam int HOLD_W  = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_e;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_bus_arbiter_pick4.sv
// Rotating-priority search: first set req bit starting at ptr+1, wrapping,
// with ptr itself examined last.
module rr_pick4
  import rr_bus_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ptr + SEL_W'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_bus_arbiter.sv
// Round-robin bus arbiter: one owner at a time, released on req drop, last
// beat, or hold-limit expiry, with back-to-back handover to the next requester.
module rr_bus_arbiter
  import rr_bus_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] last,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic               timeout
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [SEL_W-1:0]    ptr_q, ptr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                timeout_q, timeout_d;

  logic                owner_req, owner_last, hold_max, release_now;
  logic [SEL_W-1:0]    pick_ptr;
  logic                pick_found;
  logic [SEL_W-1:0]    pick_idx;

  // sel_q names the owner while OWNED, so it doubles as the owner index.
  assign owner_req   = req[sel_q];
  assign owner_last  = last[sel_q];
  assign hold_max    = (hold_q == HOLD_LAST);
  assign release_now = (state_q == ST_OWNED) && (!owner_req || owner_last || hold_max);

  // On release the search restarts just past the outgoing owner.
  assign pick_ptr = release_now ? sel_q : ptr_q;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_OWNED;
          grant_d = idx_to_onehot(pick_idx);
          sel_d   = pick_idx;
          hold_d  = '0;
        end
      end
      ST_OWNED: begin
        if (release_now) begin
          ptr_d     = sel_q;
          timeout_d = hold_max && owner_req && !owner_last;
          hold_d    = '0;
          if (pick_found) begin
            grant_d = idx_to_onehot(pick_idx);
            sel_d   = pick_idx;
          end else begin
            state_d = ST_IDLE;
            grant_d = '0;
          end
        end else if (hold_q != '1) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      sel_q     <= '0;
      ptr_q     <= SEL_W'(NUM_REQ - 1);
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant   = grant_q;
  assign sel     = sel_q;
  assign busy    = |grant_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Bench for rr_bus_arbiter: directed vector table, a hold-limit sequence,
// then randomized traffic against a queue/array-level reference model.
module tb_rr_bus_arbiter;

  localparam int MAX_HOLD = 16;

  logic       Clk;
  logic       Reset;
  logic [3:0] req;
  logic [3:0] last;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  int n_checks = 0;
  int n_errors = 0;

  rr_bus_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .req     (req),
    .last    (last),
    .grant   (grant),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: owner as an integer, search by modular arithmetic
  int         m_owner;
  int         m_ptr;
  int         m_hold;
  int         m_next;
  logic [3:0] m_grant;
  logic [1:0] m_sel;
  logic       m_to;
  bit         m_valid = 1'b0;
  bit         m_drop, m_fin, m_lim;

  function automatic int rr_search(input int p, input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  always @(posedge Clk) begin
    if (Reset) begin
      m_owner = -1; m_ptr = 3; m_hold = 0; m_sel = 2'd0; m_to = 1'b0; m_valid = 1'b1;
    end else if (m_owner < 0) begin
      m_to   = 1'b0;
      m_next = rr_search(m_ptr, req);
      if (m_next >= 0) begin
        m_owner = m_next; m_hold = 0; m_sel = 2'(m_next);
      end
    end else begin
      m_drop = !req[m_owner];
      m_fin  = last[m_owner];
      m_lim  = (m_hold == MAX_HOLD - 1);
      if (m_drop || m_fin || m_lim) begin
        m_to    = m_lim && !m_drop && !m_fin;
        m_ptr   = m_owner;
        m_next  = rr_search(m_ptr, req);
        m_owner = m_next;
        m_hold  = 0;
        if (m_next >= 0) m_sel = 2'(m_next);
      end else begin
        m_to = 1'b0;
        m_hold++;
      end
    end
    m_grant = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
  end

  // every-cycle structural checks and model comparison
  always @(negedge Clk) begin
    if (m_valid) begin
      check("invariant", {7'd0, ((grant & (grant - 4'd1)) == 4'd0) &&
                                 (grant == 4'd0 || grant == (4'b0001 << sel)) &&
                                 (busy == |grant)}, 8'd1);
      check("model_grant",   {4'd0, grant},   {4'd0, m_grant});
      check("model_sel",     {6'd0, sel},     {6'd0, m_sel});
      check("model_timeout", {7'd0, timeout}, {7'd0, m_to});
    end
  end

  a_inv: assert property (@(posedge Clk) disable iff (Reset)
    ((grant & (grant - 4'd1)) == 4'd0) && (grant == 4'd0 || grant == (4'b0001 << sel)) && (busy == |grant))
    else $error("grant/sel/busy invariant violated");

  // driver tasks
  task automatic step(input logic rst, input logic [3:0] r, input logic [3:0] l);
    Reset = rst; req = r; last = l;
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic expect_out(input string name, input logic [3:0] g, input logic [1:0] s,
                            input logic b, input logic t);
    check({name, "_grant"},   {4'd0, grant},   {4'd0, g});
    check({name, "_sel"},     {6'd0, sel},     {6'd0, s});
    check({name, "_busy"},    {7'd0, busy},    {7'd0, b});
    check({name, "_timeout"}, {7'd0, timeout}, {7'd0, t});
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] last;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       to;
  } vec_t;

  vec_t vecs[17];
  logic [3:0] r_req, r_last;

  initial begin
    // rst, req, last -> grant, sel, busy, timeout after the edge
    vecs[0]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0}; // reset state
    vecs[1]  = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0}; // 1-cycle latency
    vecs[2]  = '{1'b0, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0}; // drop+last: one release
    vecs[3]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0}; // rotation 0->1->2->3->0
    vecs[5]  = '{1'b0, 4'b1111, 4'b0001, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 4'b1111, 4'b0010, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 4'b1111, 4'b0100, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 4'b1111, 4'b1000, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 4'b0110, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0}; // owner 0 drops
    vecs[10] = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0}; // owner 1 drops
    vecs[11] = '{1'b0, 4'b0100, 4'b1000, 4'b0100, 2'd2, 1'b1, 1'b0}; // non-owner last ignored
    vecs[12] = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 4'b1000, 4'b0100, 4'b1000, 2'd3, 1'b1, 1'b0}; // handover to 3
    vecs[14] = '{1'b1, 4'b1000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0}; // reset mid-ownership
    vecs[15] = '{1'b0, 4'b1001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0}; // ptr back to 3
    vecs[16] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};

    Reset = 1'b1; req = 4'd0; last = 4'd0;
    @(negedge Clk);

    for (int i = 0; i < 17; i++) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].last);
      expect_out($sformatf("vec%0d", i), vecs[i].grant, vecs[i].sel, vecs[i].busy, vecs[i].to);
    end

    // hold limit: 16 cycles of ownership, then timeout with immediate re-grant
    step(1'b1, 4'b0000, 4'b0000);
    step(1'b0, 4'b0100, 4'b0000);
    expect_out("hold_c1", 4'b0100, 2'd2, 1'b1, 1'b0);
    for (int c = 2; c <= 16; c++) begin
      step(1'b0, 4'b0100, 4'b0000);
      expect_out($sformatf("hold_c%0d", c), 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    step(1'b0, 4'b0100, 4'b0000);
    expect_out("hold_c17", 4'b0100, 2'd2, 1'b1, 1'b1);
    step(1'b0, 4'b0100, 4'b0000);
    expect_out("hold_c18", 4'b0100, 2'd2, 1'b1, 1'b0);

    // timeout with another requester waiting: it takes the bus
    for (int c = 0; c < 14; c++) step(1'b0, 4'b0100, 4'b0000);
    step(1'b0, 4'b0101, 4'b0000);
    expect_out("to_handover", 4'b0001, 2'd0, 1'b1, 1'b1);
    // last at the hold limit is a normal release
    for (int c = 0; c < 15; c++) step(1'b0, 4'b0001, 4'b0000);
    step(1'b0, 4'b0001, 4'b0001);
    expect_out("last_at_limit", 4'b0001, 2'd0, 1'b1, 1'b0);
    step(1'b0, 4'b0000, 4'b0000);
    expect_out("idle_again", 4'b0000, 2'd0, 1'b0, 1'b0);

    // randomized traffic, checked by the model every cycle
    for (int n = 0; n < 3000; n++) begin
      r_req = 4'($urandom_range(0, 15));
      if (m_owner >= 0 && $urandom_range(0, 31) != 0) r_req[m_owner] = 1'b1;
      if ($urandom_range(0, 24) == 0) r_req = 4'd0;
      r_last = 4'd0;
      if ($urandom_range(0, 29) == 0) r_last = 4'($urandom_range(1, 15));
      step(($urandom_range(0, 299) == 0), r_req, r_last);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rr_bus_arbiter.md
RR_BUS_ARBITER -- requirements
Module: rr_bus_arbiter

Interface
REQ-001 The block SHALL have one parameter: MAX_HOLD, default 16, maximum number of consecutive cycles one requester SHALL hold the bus (2..255).
REQ-002 The block SHALL have port Clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port req, input, 4 bits: bus request per requester; bit i is requester i.
REQ-005 The block SHALL have port last, input, 4 bits: final-beat flag per requester; sampled only for the current owner.
REQ-006 The block SHALL have port grant, output, 4 bits: registered one-hot grant, or all-zero.
REQ-007 The block SHALL have port sel, output, 2 bits: registered binary index of the owner, driving the 32-bit 4:1 result-bus mux select.
REQ-008 The block SHALL have port busy, output, 1 bit: high when any grant bit is high.
REQ-009 The block SHALL have port timeout, output, 1 bit: one-cycle pulse on a forced release.

Function
REQ-010 The FSM SHALL have two states: IDLE (no owner) and OWNED (one owner, grant[owner]=1).
REQ-011 IDLE, req==0: the block SHALL stay in IDLE with grant=0 and sel holding its last value.
REQ-012 IDLE, req!=0: the next cycle SHALL be OWNED, with the owner being the first set req bit searched from ptr+1 upward, modulo 4. Latency from req to grant is exactly 1 cycle.
REQ-013 The owner SHALL release on the first edge where any of the following holds in OWNED: req[owner]==0, last[owner]==1, or hold_cnt==MAX_HOLD-1.
REQ-014 On release, ptr SHALL be set to owner. The next owner SHALL be chosen in the same cycle from the current req, using the REQ-012 search with the updated ptr.
REQ-015 Back-to-back ownership: if the REQ-014 search finds a requester, grant SHALL switch directly to it on the next edge with no idle cycle; otherwise the state SHALL return to IDLE.
REQ-016 If the releasing owner is the only requester, it MAY be re-granted immediately. Other requesters always rank ahead of it.
REQ-017 hold_cnt SHALL be 8 bits, cleared on every new grant and incremented each OWNED cycle without release. It SHALL never wrap.
REQ-018 timeout SHALL pulse for exactly the one cycle after a release caused solely by hold_cnt (req[owner]=1, last[owner]=0).
REQ-019 The block SHALL ignore last bits of non-owners, and SHALL ignore req changes of non-owners until the next arbitration point.
REQ-020 grant and sel SHALL always be consistent: when grant!=0, sel==index of the set bit.
REQ-021 When req[owner] falls and last[owner] rises in the same cycle, the block SHALL treat it as a single release, with timeout=0.

Reset
REQ-022 While Reset=1 at an edge, the block SHALL set state=IDLE, grant=0000, sel=00, busy=0, timeout=0, hold_cnt=0 and ptr=3, so that requester 0 has highest priority first.
REQ-023 Reset asserted mid-ownership SHALL drop grant on that edge, with no timeout pulse. The first grant after reset SHALL follow REQ-012 with ptr=3.

Structure
REQ-024 A shared package SHALL hold the state encoding (IDLE=0, OWNED=1), the requester count (4), and the select width (2).
REQ-025 The rotating-priority search SHALL be one combinational sub-module, rr_pick4 (inputs req and ptr; outputs found and idx), used by both REQ-012 and REQ-014.
REQ-026 grant, sel, timeout, ptr and hold_cnt SHALL all be registers. busy SHALL be derived only from registered grant.

Verification
REQ-027 Reset then req=0001 -> one cycle later grant=0001, sel=00, busy=1. Then last[0]=1 for one cycle -> next cycle grant=0000, busy=0.
REQ-028 req=1111 held with last pulsed each ownership -> grant sequence 0001,0010,0100,1000,0001 with no idle cycles between.
REQ-029 req=0100 held and last=0, MAX_HOLD=16 -> grant=0100 for exactly 16 cycles; timeout=1 on cycle 17, with 0100 re-granted on that same cycle.
REQ-030 Owner 1 with req=0110: drop req[1] -> next cycle grant=0100, sel=10. A last[3] pulse while owner is 2 -> no effect.
REQ-031 Reset asserted while grant=1000 -> next cycle grant=0000, sel=00. Then req=1001 -> grant=0001.
REQ-032 Every cycle, an assertion SHALL check grant one-hot-or-zero, grant/sel consistency, and busy==|grant.
